controle_painel: RTL and testbench
==================================

Name: controle_painel

Overview:
Sequencer that drives the shared mode-select pair (ch0, ch1) of the five-row universal-register bank of the digital display panel. It loads the stored message pattern, then rotates it at a programmable scroll rate in a selectable direction, with pause and stop.
It also reports the current rotation offset and a per-lap pulse to the panel status logic. It sits directly upstream of the register bank; its ch0/ch1 outputs connect to every row register.

Parameters:
PRESCALE, 25000000, clock cycles spent in SHOW per scroll step (0.5 s at 50 MHz); legal range >= 1
WIDTH, 16, row register length; pos wraps modulo WIDTH

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous reset, active-low
start  input  1  level-sampled each cycle; requests load and scroll
stop  input  1  level-sampled; returns to IDLE
pause  input  1  freezes scroll timing while high
dir  input  1  0 = shift right, 1 = shift left
ch0  output  1  mode select bit 0 to register bank
ch1  output  1  mode select bit 1 to register bank
pos  output  4  current rotation offset, 0..WIDTH-1
busy  output  1  high in every state except IDLE
volta  output  1  one-cycle pulse when pos wraps

Behaviour:
- Mode encoding {ch1,ch0}, fixed bank-wide: 00 hold, 01 rotate right, 10 rotate left, 11 parallel load.
- All outputs are registered and updated on the same edge as the state register. The ch code is therefore valid for exactly the cycles the FSM occupies a state.
- Reset (rst=0, asynchronous):
  - state = IDLE, {ch1,ch0} = 00, pos = 0, busy = 0, volta = 0.
  - Prescaler = 0, latched direction = 0.
  - Release is synchronous to the next clk edge.
- States:
  - IDLE: ch = 00, busy = 0. start = 1 -> LOAD.
  - LOAD: exactly 1 cycle, ch = 11, busy = 1. pos cleared to 0 and prescaler cleared. Always -> SHOW.
  - SHOW: ch = 00.
    - Prescaler increments each cycle when pause = 0; holds when pause = 1.
    - On the cycle the prescaler equals PRESCALE-1 with pause = 0: prescaler <- 0, dir is latched, next state = SHIFT.
  - SHIFT: exactly 1 cycle, ch = 01 (latched dir = 0) or 10 (latched dir = 1). Always -> SHOW.
    - pos update: dir = 0 gives pos <- (pos+1) mod WIDTH; dir = 1 gives pos <- (pos-1) mod WIDTH.
    - volta = 1 in the cycle after the SHIFT that makes pos = 0 (wrap in either direction), else 0.
- Timing: scroll period = PRESCALE+1 cycles (PRESCALE in SHOW + 1 in SHIFT). First SHIFT occurs PRESCALE cycles after LOAD.
- Priorities, evaluated every cycle:
  - stop > start > normal transition.
  - stop = 1 in any state -> IDLE next cycle, ch = 00. pos holds its value, prescaler cleared.
  - start = 1 while in SHOW or SHIFT (stop = 0) -> LOAD (restart from pos 0).
  - start held high continuously re-enters LOAD every cycle. Upstream delivers start as a 1-cycle pulse.
  - start and stop both high: stop wins.
- dir is sampled only at the SHOW->SHIFT decision. Changes at other times take effect on the next step.
- pause has no effect in IDLE, LOAD or SHIFT; a SHIFT already entered completes.
- PRESCALE = 1: SHOW lasts 1 cycle, so states alternate SHOW/SHIFT and a step occurs every 2 cycles.
- Reset mid-LOAD or mid-SHIFT aborts immediately; ch drops to 00 asynchronously.

Test Plan:
- Reset and idle (PRESCALE=4): rst low 3 cycles then high, start=0 for 10 cycles -> ch=00, busy=0, pos=0, volta=0 throughout.
- Load and right scroll (PRESCALE=4): start pulse, dir=0 ->
  - next cycle ch=11 for 1 cycle;
  - then 4 cycles ch=00;
  - then 1 cycle ch=01 with pos 0->1;
  - steps repeat every 5 cycles.
- Wrap: continue right scroll for 16 steps -> pos 15->0 and volta=1 for exactly 1 cycle. With dir=1 from pos=0, first step gives pos=15 and no volta; volta pulses when pos returns to 0.
- Pause: assert pause 7 cycles mid-SHOW at prescaler=2 -> ch stays 00, no SHIFT. After release, SHIFT occurs 2 cycles later (prescaler resumes at 2).
- Stop/start priority: stop during SHIFT with pos=5 -> IDLE next cycle, ch=00, busy=0, pos=5. start+stop same cycle -> stays IDLE. Later start alone -> LOAD, pos=0.
- Async reset mid-run: drop rst between clock edges during SHIFT -> ch=00 and pos=0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/controle_painel.sv
// rtl/controle_painel.sv - mode-select sequencer for the five-row scrolling display register bank
// Loads the message, then rotates it at a prescaled rate; all outputs are registered.

module controle_painel #(
    parameter int PRESCALE = 25000000,
    parameter int WIDTH    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       pause,
    input  logic       dir,
    output logic       ch0,
    output logic       ch1,
    output logic [3:0] pos,
    output logic       busy,
    output logic       volta
);

    localparam int             PW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]  PLAST = PW'(PRESCALE - 1);
    localparam logic [3:0]     PMAX  = 4'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHOW, SHIFT} state_t;

    state_t        state, state_n;
    logic [PW-1:0] presc, presc_n;
    logic          dir_q, dir_q_n;
    logic [1:0]    ch, ch_n;
    logic [3:0]    pos_n, pos_step;
    logic          busy_n, volta_n;

    assign {ch1, ch0} = ch;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            presc <= '0;
            dir_q <= 1'b0;
            ch    <= 2'b00;
            pos   <= 4'd0;
            busy  <= 1'b0;
            volta <= 1'b0;
        end else begin
            state <= state_n;
            presc <= presc_n;
            dir_q <= dir_q_n;
            ch    <= ch_n;
            pos   <= pos_n;
            busy  <= busy_n;
            volta <= volta_n;
        end
    end

    always_comb begin
        state_n = state;
        if (stop) begin
            state_n = IDLE;
        end else if (start) begin
            state_n = LOAD;
        end else begin
            case (state)
                IDLE:    state_n = IDLE;
                LOAD:    state_n = SHOW;
                SHOW:    state_n = (!pause && presc == PLAST) ? SHIFT : SHOW;
                SHIFT:   state_n = SHOW;
                default: state_n = IDLE;
            endcase
        end
    end

    // pos tracks the bank content, so it moves on the edge that ends SHIFT
    always_comb begin
        pos_step = dir_q ? ((pos == 4'd0) ? PMAX : pos - 4'd1)
                         : ((pos == PMAX) ? 4'd0 : pos + 4'd1);

        ch_n = 2'b00;
        case (state_n)
            LOAD:    ch_n = 2'b11;
            SHIFT:   ch_n = dir ? 2'b10 : 2'b01;
            default: ch_n = 2'b00;
        endcase

        busy_n = (state_n != IDLE);

        presc_n = '0;
        if (state == SHOW && state_n == SHOW)
            presc_n = pause ? presc : presc + 1'b1;

        dir_q_n = (state == SHOW && state_n == SHIFT) ? dir : dir_q;

        pos_n   = pos;
        volta_n = 1'b0;
        if (state_n == LOAD) begin
            pos_n = 4'd0;
        end else if (state == SHIFT && state_n == SHOW) begin
            pos_n   = pos_step;
            volta_n = (pos_step == 4'd0);
        end
    end

endmodule

// File: tb/tb_controle_painel.sv
// tb/tb_controle_painel.sv - randomized and scenario bench for controle_painel against a countdown model

module tb_controle_painel;

    localparam int P = 4;
    localparam int W = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0, stop = 1'b0, pause = 1'b0, dir = 1'b0;
    logic       ch0, ch1, busy, volta;
    logic [3:0] pos;

    int n_vec = 0;
    int n_err = 0;

    // model: outputs plus a countdown of unpaused SHOW cycles left before the next step
    logic [1:0] m_ch;
    logic [3:0] m_pos;
    logic       m_busy, m_volta, m_dir;
    int         m_wait;

    controle_painel #(.PRESCALE(P), .WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause), .dir(dir),
        .ch0(ch0), .ch1(ch1), .pos(pos), .busy(busy), .volta(volta)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_ch = 2'b00; m_pos = 4'd0; m_busy = 1'b0; m_volta = 1'b0; m_dir = 1'b0; m_wait = 0;
    endtask

    task automatic model_step(input logic s, input logic p, input logic pa, input logic d);
        logic loading, shifting, showing;
        loading  = (m_ch == 2'b11);
        shifting = (m_ch == 2'b01 || m_ch == 2'b10);
        showing  = m_busy && (m_ch == 2'b00);
        m_volta  = 1'b0;
        if (p) begin
            m_busy = 1'b0; m_ch = 2'b00;
        end else if (s) begin
            m_busy = 1'b1; m_ch = 2'b11; m_pos = 4'd0; m_wait = P;
        end else if (loading) begin
            m_ch = 2'b00; m_wait = P;
        end else if (shifting) begin
            m_pos   = 4'((int'(m_pos) + (m_dir ? W - 1 : 1)) % W);
            m_volta = (m_pos == 4'd0);
            m_ch    = 2'b00;
            m_wait  = P;
        end else if (showing && !pa) begin
            m_wait = m_wait - 1;
            if (m_wait == 0) begin
                m_dir = d;
                m_ch  = d ? 2'b10 : 2'b01;
            end
        end
    endtask

    // caller sits 1 time unit after an active edge; returns 1 unit after the next one
    task automatic step(input logic s, input logic p, input logic pa, input logic d);
        start = s; stop = p; pause = pa; dir = d;
        @(posedge clk);
        model_step(s, p, pa, d);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        model_reset();
        repeat (3) begin
            @(posedge clk); #1;
            n_vec++;
            if ({ch1, ch0, pos, busy, volta} !== 8'h00) begin
                n_err++;
                $display("FAIL reset_hold: got ch=%b%b pos=%0d busy=%b volta=%b, want all 0", ch1, ch0, pos, busy, volta);
            end
        end
        rst = 1'b1;
        repeat (10) begin
            step(0, 0, 0, 0);
            n_vec++;
            if ({ch1, ch0, pos, busy, volta} !== 8'h00) begin
                n_err++;
                $display("FAIL idle: got ch=%b%b pos=%0d busy=%b volta=%b, want all 0", ch1, ch0, pos, busy, volta);
            end
        end
    endtask

    task automatic test_right_scroll();
        logic [1:0] exp_ch [7] = '{2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00};
        logic [3:0] exp_pos[7] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1};
        for (int i = 0; i < 7; i++) begin
            step(i == 0, 0, 0, 0);
            n_vec++;
            if ({ch1, ch0} !== exp_ch[i] || pos !== exp_pos[i] || busy !== 1'b1) begin
                n_err++;
                $display("FAIL right_seq[%0d]: got ch=%b%b pos=%0d busy=%b, want ch=%b pos=%0d busy=1",
                         i, ch1, ch0, pos, busy, exp_ch[i], exp_pos[i]);
            end
        end
    endtask

    task automatic test_wrap(input logic d);
        int pulses;
        if (d) begin
            for (int i = 0; i < 7; i++) step(i == 0, 0, 0, 1);
            n_vec++;
            if (pos !== 4'd15 || volta !== 1'b0) begin
                n_err++;
                $display("FAIL left_first: got pos=%0d volta=%b, want pos=15 volta=0", pos, volta);
            end
        end
        pulses = 0;
        for (int i = 0; i < 80; i++) begin
            step(0, 0, 0, d);
            if (volta === 1'b1) begin
                pulses++;
                n_vec++;
                if (pos !== 4'd0) begin
                    n_err++;
                    $display("FAIL wrap_pos dir=%b: volta with pos=%0d, want 0", d, pos);
                end
            end
            n_vec++;
            if ({ch1, ch0, pos, busy, volta} !== {m_ch, m_pos, m_busy, m_volta}) begin
                n_err++;
                $display("FAIL wrap_model dir=%b: got ch=%b%b pos=%0d volta=%b, want ch=%b pos=%0d volta=%b",
                         d, ch1, ch0, pos, volta, m_ch, m_pos, m_volta);
            end
        end
        n_vec++;
        if (pulses != 1) begin
            n_err++;
            $display("FAIL wrap_count dir=%b: got %0d volta pulses, want 1", d, pulses);
        end
    endtask

    task automatic test_pause();
        for (int i = 0; i < 4; i++) step(i == 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) begin
            step(0, 0, 1, 0);
            n_vec++;
            if ({ch1, ch0} !== 2'b00 || busy !== 1'b1) begin
                n_err++;
                $display("FAIL pause_hold[%0d]: got ch=%b%b busy=%b, want ch=00 busy=1", i, ch1, ch0, busy);
            end
        end
        step(0, 0, 0, 0);
        n_vec++;
        if ({ch1, ch0} !== 2'b00) begin
            n_err++;
            $display("FAIL pause_resume1: got ch=%b%b, want 00", ch1, ch0);
        end
        step(0, 0, 0, 0);
        n_vec++;
        if ({ch1, ch0} !== 2'b01 || pos !== 4'd0) begin
            n_err++;
            $display("FAIL pause_resume2: got ch=%b%b pos=%0d, want ch=01 pos=0", ch1, ch0, pos);
        end
    endtask

    task automatic test_stop_start();
        bit found = 0;
        step(1, 0, 0, 0);
        for (int i = 0; i < 100 && !found; i++) begin
            step(0, 0, 0, 0);
            found = ({ch1, ch0} == 2'b01 && pos == 4'd5);
        end
        n_vec++;
        if (!found) begin
            n_err++;
            $display("FAIL stop_reach: SHIFT at pos=5 not seen within 100 cycles, got pos=%0d", pos);
        end
        step(0, 1, 0, 0);
        n_vec++;
        if ({ch1, ch0} !== 2'b00 || busy !== 1'b0 || pos !== 4'd5) begin
            n_err++;
            $display("FAIL stop_shift: got ch=%b%b busy=%b pos=%0d, want ch=00 busy=0 pos=5", ch1, ch0, busy, pos);
        end
        step(1, 1, 0, 0);
        n_vec++;
        if ({ch1, ch0} !== 2'b00 || busy !== 1'b0 || pos !== 4'd5) begin
            n_err++;
            $display("FAIL stop_wins: got ch=%b%b busy=%b pos=%0d, want ch=00 busy=0 pos=5", ch1, ch0, busy, pos);
        end
        step(1, 0, 0, 0);
        n_vec++;
        if ({ch1, ch0} !== 2'b11 || busy !== 1'b1 || pos !== 4'd0) begin
            n_err++;
            $display("FAIL restart: got ch=%b%b busy=%b pos=%0d, want ch=11 busy=1 pos=0", ch1, ch0, busy, pos);
        end
    endtask

    task automatic test_async_reset();
        bit found = 0;
        step(1, 0, 0, 0);
        for (int i = 0; i < 100 && !found; i++) begin
            step(0, 0, 0, 0);
            found = ({ch1, ch0} == 2'b01 && pos == 4'd1);
        end
        n_vec++;
        if (!found) begin
            n_err++;
            $display("FAIL areset_reach: SHIFT at pos=1 not seen within 100 cycles");
        end
        #2 rst = 1'b0;
        #1;
        n_vec++;
        if ({ch1, ch0} !== 2'b00 || pos !== 4'd0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL areset_now: got ch=%b%b pos=%0d busy=%b, want ch=00 pos=0 busy=0", ch1, ch0, pos, busy);
        end
        model_reset();
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_random();
        logic s, p, pa, d;
        pa = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            s = ($urandom_range(0, 29) == 0);
            p = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 5) == 0) pa = ~pa;
            d = $urandom_range(0, 1);
            step(s, p, pa, d);
            n_vec++;
            if ({ch1, ch0, pos, busy, volta} !== {m_ch, m_pos, m_busy, m_volta}) begin
                n_err++;
                $display("FAIL random[%0d]: got ch=%b%b pos=%0d busy=%b volta=%b, want ch=%b pos=%0d busy=%b volta=%b",
                         i, ch1, ch0, pos, busy, volta, m_ch, m_pos, m_busy, m_volta);
            end
        end
    endtask

    initial begin
        test_reset();
        test_right_scroll();
        test_wrap(1'b0);
        test_wrap(1'b1);
        step(0, 1, 0, 0);
        test_pause();
        step(0, 1, 0, 0);
        test_stop_start();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
